// File: rtl/edge_bus_master_if.sv
// Pixel-memory bus between the edge-core bus master and the memory responder.
interface edge_bus_master_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;

  modport master (output haddr, output hwrite, output hwdata, input hrdata, input hready);
  modport slave  (input haddr, input hwrite, input hwdata, output hrdata, output hready);
endinterface

// File: rtl/edge_bus_master.sv
// Bus initiator for the edge-detection core: posted write FIFO, single-pixel read
// shadow at the current haddr, transaction timeout and synchronous abort.
module edge_bus_master #(
  parameter int ADDR_W      = 18,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              stop,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic              wr_req,
  output logic              wr_full,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [23:0]       wr_pixel,
  output logic [23:0]       rd_pixel,
  output logic              rd_valid,
  output logic              bus_err,
  output logic              busy,
  edge_bus_master_if.master bus
);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] ADDR_NONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state_q, state_d;
  logic [31:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic [23:0]       rd_pixel_q, rd_pixel_d;
  logic              rd_valid_q, rd_valid_d;
  logic              bus_err_q, bus_err_d;
  logic [23:0]       shadow_q, shadow_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [23:0]       fifo_pix  [WFIFO_DEPTH];

  logic push, pop, flush, abort, fifo_empty, rd_acc, shadow_hit, tmo_hit;
  logic unused_hrdata_lsb;

  function automatic logic [31:0] ext(input logic [ADDR_W-1:0] a);
    return 32'(a);
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign wr_full    = (cnt_q == CNT_W'(WFIFO_DEPTH));
  assign rd_ready   = (state_q == IDLE) && fifo_empty && !stop;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign push       = wr_req && !wr_full && !stop;
  // A write in the same cycle takes the slot; the read is retried once the FIFO drains.
  assign rd_acc     = rd_req && rd_ready && !wr_req;
  assign shadow_hit = shadow_vld_q && (ext(req_addr) == haddr_q);
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  assign rd_pixel   = rd_pixel_q;
  assign rd_valid   = rd_valid_q;
  assign bus_err    = bus_err_q;
  assign bus.haddr  = haddr_q;
  assign bus.hwrite = hwrite_q;
  assign bus.hwdata = hwdata_q;
  assign unused_hrdata_lsb = ^bus.hrdata[7:0];

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hwdata_d     = hwdata_q;
    rd_pixel_d   = rd_pixel_q;
    rd_valid_d   = 1'b0;
    bus_err_d    = 1'b0;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    tmo_d        = tmo_q;
    pop          = 1'b0;
    flush        = 1'b0;
    abort        = 1'b0;
    if (stop) begin
      state_d      = IDLE;
      hwrite_d     = 1'b0;
      haddr_d      = ADDR_NONE;
      shadow_vld_d = 1'b0;
      flush        = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_d  = WR;
            haddr_d  = ext(fifo_addr[rptr_q]);
            hwdata_d = {8'h00, fifo_pix[rptr_q]};
            hwrite_d = 1'b1;
            tmo_d    = '0;
          end else if (rd_acc) begin
            if (shadow_hit) begin
              rd_pixel_d = shadow_q;
              rd_valid_d = 1'b1;
            end else begin
              haddr_d = ext(req_addr);
              state_d = RD;
              tmo_d   = '0;
            end
          end
        end
        RD: begin
          if (bus.hready) begin
            rd_pixel_d   = bus.hrdata[31:8];
            shadow_d     = bus.hrdata[31:8];
            shadow_vld_d = 1'b1;
            rd_valid_d   = 1'b1;
            state_d      = IDLE;
          end else if (tmo_hit) begin
            abort = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        WR: begin
          if (bus.hready) begin
            pop          = 1'b1;
            shadow_d     = fifo_pix[rptr_q];
            shadow_vld_d = 1'b1;
            hwrite_d     = 1'b0;
            state_d      = IDLE;
          end else if (tmo_hit) begin
            pop   = 1'b1;
            abort = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (abort) begin
        bus_err_d    = 1'b1;
        hwrite_d     = 1'b0;
        haddr_d      = ADDR_NONE;
        shadow_vld_d = 1'b0;
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      haddr_q      <= ADDR_NONE;
      hwrite_q     <= 1'b0;
      hwdata_q     <= '0;
      rd_pixel_q   <= '0;
      rd_valid_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      tmo_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hwdata_q     <= hwdata_d;
      rd_pixel_q   <= rd_pixel_d;
      rd_valid_q   <= rd_valid_d;
      bus_err_q    <= bus_err_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      tmo_q        <= tmo_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr_q] <= req_addr;
      fifo_pix[wptr_q]  <= wr_pixel;
    end
  end
endmodule

// File: tb/tb_edge_bus_master.sv
// Scoreboard bench for edge_bus_master: a responder models pixel memory, a monitor
// pops expected reads/writes as the DUT completes them.
module tb_edge_bus_master;
  localparam int ADDR_W = 18;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wexp_t;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              stop = 1'b0;
  logic              rd_req = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [23:0]       wr_pixel = '0;
  logic              rd_ready, wr_full, rd_valid, bus_err, busy;
  logic [23:0]       rd_pixel;

  edge_bus_master_if bus();

  edge_bus_master #(.ADDR_W(ADDR_W), .WFIFO_DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .n_rst(n_rst), .stop(stop),
    .rd_req(rd_req), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_full(wr_full),
    .req_addr(req_addr), .wr_pixel(wr_pixel),
    .rd_pixel(rd_pixel), .rd_valid(rd_valid),
    .bus_err(bus_err), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          rd_bus_cnt = 0;
  int          err_cnt = 0;
  bit          resp_en = 1'b1;
  bit          saw_low = 1'b1;
  logic [23:0] rd_q[$];
  wexp_t       wr_q[$];
  logic [23:0] mem [logic [31:0]];
  logic [31:0] last_addr;

  // Memory responder: answers one cycle after haddr changes or hwrite rises.
  initial begin
    bus.hready = 1'b0;
    bus.hrdata = '0;
    last_addr  = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk);
      #2;
      if (!n_rst) begin
        bus.hready = 1'b0;
        last_addr  = 32'hFFFF_FFFF;
      end else if (bus.hready) begin
        bus.hready = 1'b0;
      end else if (resp_en && (bus.hwrite || bus.haddr != last_addr)) begin
        last_addr = bus.haddr;
        if (bus.hwrite) mem[bus.haddr] = bus.hwdata[23:0];
        bus.hrdata = mem.exists(bus.haddr) ? {mem[bus.haddr], 8'h00} : 32'h0;
        bus.hready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops and bus activity accounting.
  initial begin
    logic [23:0] exp_px;
    wexp_t       we;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (rd_valid) begin
          chk_cnt++;
          if (rd_q.size() == 0) begin
            $display("FAIL rd_valid_unexpected got pulse rd_pixel=%h want no pulse", rd_pixel);
          end else begin
            exp_px = rd_q.pop_front();
            if (rd_pixel !== exp_px) $display("FAIL rd_pixel got %h want %h", rd_pixel, exp_px);
            else pass_cnt++;
          end
        end
        if (bus.hwrite && bus.hready) begin
          chk_cnt++;
          if (wr_q.size() == 0) begin
            $display("FAIL bus_write_unexpected got addr %h want none", bus.haddr);
          end else begin
            we = wr_q.pop_front();
            if (bus.haddr !== we.a || bus.hwdata !== we.d)
              $display("FAIL bus_write got %h/%h want %h/%h", bus.haddr, bus.hwdata, we.a, we.d);
            else pass_cnt++;
          end
          chk_cnt++;
          if (saw_low !== 1'b1) $display("FAIL hwrite_gap got no idle cycle want >=1");
          else pass_cnt++;
          saw_low = 1'b0;
        end
        if (!bus.hwrite) saw_low = 1'b1;
        if (bus.hready && !bus.hwrite && bus.haddr != 32'hFFFF_FFFF) rd_bus_cnt++;
        if (bus_err) err_cnt++;
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [23:0] exp, input bit expect_data);
    int n = 0;
    @(negedge clk);
    while (!rd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rd_ready) begin
      chk_cnt++;
      $display("FAIL rd_ready_wait got 0 want 1");
    end
    rd_req   = 1'b1;
    req_addr = a;
    if (expect_data) rd_q.push_back(exp);
    @(posedge clk);
    #1 rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [23:0] pix);
    int n = 0;
    wexp_t we;
    @(negedge clk);
    while (wr_full && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (wr_full) begin
      chk_cnt++;
      $display("FAIL wr_full_wait got 1 want 0");
    end
    wr_req   = 1'b1;
    req_addr = a;
    wr_pixel = pix;
    we.a = 32'(a);
    we.d = {8'h00, pix};
    wr_q.push_back(we);
    @(posedge clk);
    #1 wr_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 300 && (busy || rd_q.size() != 0 || wr_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (busy || rd_q.size() != 0 || wr_q.size() != 0)
      $display("FAIL %s_done got busy=%b rd_q=%0d wr_q=%0d want idle", name, busy, rd_q.size(), wr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.haddr !== 32'hFFFF_FFFF) $display("FAIL reset_haddr got %h want ffffffff", bus.haddr); else pass_cnt++;
    chk_cnt++; if (bus.hwrite !== 1'b0) $display("FAIL reset_hwrite got %b want 0", bus.hwrite); else pass_cnt++;
    chk_cnt++; if (bus.hwdata !== 32'h0) $display("FAIL reset_hwdata got %h want 0", bus.hwdata); else pass_cnt++;
    chk_cnt++; if (rd_pixel !== 24'h0) $display("FAIL reset_rd_pixel got %h want 0", rd_pixel); else pass_cnt++;
    chk_cnt++; if ({rd_valid, bus_err, busy, wr_full} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {rd_valid, bus_err, busy, wr_full}); else pass_cnt++;
    chk_cnt++; if (rd_ready !== 1'b1) $display("FAIL reset_rd_ready got %b want 1", rd_ready); else pass_cnt++;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_miss();
    int c0 = rd_bus_cnt;
    mem[32'd5] = 24'hAABBCC;
    do_read(18'd5, 24'hAABBCC, 1'b1);
    wait_done("read_miss");
    chk_cnt++; if (bus.haddr !== 32'd5) $display("FAIL read_miss_haddr got %h want 5", bus.haddr); else pass_cnt++;
    chk_cnt++; if (bus.hwrite !== 1'b0) $display("FAIL read_miss_hwrite got %b want 0", bus.hwrite); else pass_cnt++;
    chk_cnt++; if (rd_bus_cnt !== c0 + 1) $display("FAIL read_miss_bus got %0d want %0d", rd_bus_cnt, c0 + 1); else pass_cnt++;
  endtask

  task automatic test_read_hit();
    int c0 = rd_bus_cnt;
    do_read(18'd5, 24'hAABBCC, 1'b1);
    @(negedge clk);
    chk_cnt++; if (rd_valid !== 1'b1) $display("FAIL read_hit_latency got %b want 1", rd_valid); else pass_cnt++;
    wait_done("read_hit");
    chk_cnt++; if (rd_bus_cnt !== c0) $display("FAIL read_hit_bus got %0d want %0d", rd_bus_cnt, c0); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'd5) $display("FAIL read_hit_haddr got %h want 5", bus.haddr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) do_write(ADDR_W'(10 + i), 24'h010203 + 24'(i) * 24'h030303);
    chk_cnt++; if (wr_full !== 1'b1) $display("FAIL b2b_wr_full got %b want 1", wr_full); else pass_cnt++;
    chk_cnt++; if ({rd_ready, busy} !== 2'b01) $display("FAIL b2b_ready_busy got %b want 01", {rd_ready, busy}); else pass_cnt++;
    resp_en = 1'b1;
    wait_done("b2b");
    chk_cnt++; if (wr_full !== 1'b0) $display("FAIL b2b_drained got %b want 0", wr_full); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'd13) $display("FAIL b2b_last_haddr got %h want d", bus.haddr); else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    int c0;
    do_write(18'd7, 24'h123456);
    wait_done("wr7");
    c0 = rd_bus_cnt;
    do_read(18'd7, 24'h123456, 1'b1);
    wait_done("rd7");
    chk_cnt++; if (rd_bus_cnt !== c0) $display("FAIL wr_shadow_bus got %0d want %0d", rd_bus_cnt, c0); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int c_err = err_cnt;
    int c0;
    resp_en = 1'b0;
    do_read(18'd20, 24'h0, 1'b0);
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus_err) break;
    end
    chk_cnt++; if (n !== 64) $display("FAIL timeout_cycles got %0d want 64", n); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'hFFFF_FFFF) $display("FAIL timeout_haddr got %h want ffffffff", bus.haddr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (err_cnt !== c_err + 1 || bus_err !== 1'b0) $display("FAIL timeout_pulse got %0d/%b want %0d/0", err_cnt, bus_err, c_err + 1); else pass_cnt++;
    resp_en = 1'b1;
    mem[32'd20] = 24'h55AA33;
    repeat (3) @(negedge clk);
    c0 = rd_bus_cnt;
    do_read(18'd20, 24'h55AA33, 1'b1);
    wait_done("timeout_retry");
    chk_cnt++; if (rd_bus_cnt !== c0 + 1) $display("FAIL timeout_reissue got %0d want %0d", rd_bus_cnt, c0 + 1); else pass_cnt++;
  endtask

  task automatic test_stop();
    int c_err;
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) do_write(ADDR_W'(40 + i), 24'hC0C000 + 24'(i));
    @(negedge clk);
    chk_cnt++; if (bus.hwrite !== 1'b1) $display("FAIL stop_pre_hwrite got %b want 1", bus.hwrite); else pass_cnt++;
    c_err = err_cnt;
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk_cnt++; if ({bus.hwrite, busy, wr_full} !== 3'b000) $display("FAIL stop_flags got %b want 000", {bus.hwrite, busy, wr_full}); else pass_cnt++;
    chk_cnt++; if (bus.haddr !== 32'hFFFF_FFFF) $display("FAIL stop_haddr got %h want ffffffff", bus.haddr); else pass_cnt++;
    wr_q.delete();
    repeat (3) @(negedge clk);
    chk_cnt++; if (err_cnt !== c_err) $display("FAIL stop_no_err got %0d want %0d", err_cnt, c_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_rd();
    int c0;
    do_read(18'd30, 24'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_rd_busy got %b want 1", busy); else pass_cnt++;
    #1 n_rst = 1'b0;
    #1;
    chk_cnt++; if (bus.haddr !== 32'hFFFF_FFFF || bus.hwdata !== 32'h0) $display("FAIL mid_rd_reset_bus got %h/%h want ffffffff/0", bus.haddr, bus.hwdata); else pass_cnt++;
    chk_cnt++; if ({bus.hwrite, busy, rd_valid} !== 3'b000) $display("FAIL mid_rd_reset_flags got %b want 000", {bus.hwrite, busy, rd_valid}); else pass_cnt++;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    resp_en = 1'b1;
    repeat (3) @(negedge clk);
    c0 = rd_bus_cnt;
    do_read(18'd5, 24'hAABBCC, 1'b1);
    wait_done("post_reset_read");
    chk_cnt++; if (rd_bus_cnt !== c0 + 1) $display("FAIL post_reset_bus got %0d want %0d", rd_bus_cnt, c0 + 1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_back_to_back();
    test_write_then_read();
    test_timeout();
    test_stop();
    test_reset_mid_rd();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
